// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and a 256-bit line memory.
// Hits complete combinationally in IDLE; a miss stalls through an optional write-back and then a refill.
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 32 - 5 - INDEX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t              r_state, w_state_next;
  logic [LINES-1:0]    r_valid, r_dirty;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [LINE_W-1:0]   r_data [LINES];
  logic [TAG_W-1:0]    r_req_tag;
  logic [INDEX_W-1:0]  r_req_idx;

  logic                r_mem_enable, w_mem_enable_next;
  logic                r_mem_write,  w_mem_write_next;
  logic [31:0]         r_mem_addr,   w_mem_addr_next;
  logic [LINE_W-1:0]   r_mem_data,   w_mem_data_next;

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [2:0]          w_word;
  logic [LINE_W-1:0]   w_line;
  logic [31:0]         w_rd_word;
  logic                w_req, w_hit, w_miss, w_write_hit, w_refill_done;
  logic                w_unused;

  assign w_idx    = p1_addr_i[5 +: INDEX_W];
  assign w_tag    = p1_addr_i[31 -: TAG_W];
  assign w_word   = p1_addr_i[4:2];
  assign w_unused = &{1'b0, p1_addr_i[1:0]};

  assign w_line    = r_data[w_idx];
  assign w_rd_word = w_line[{w_word, 5'b0} +: 32];

  // Hit is gated by reset so a request held high during reset cannot touch the arrays or stall.
  assign w_req         = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit         = rst_i & (r_state == IDLE) & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss        = (r_state == IDLE) & w_req & ~w_hit;
  assign w_write_hit   = w_hit & p1_MemWrite_i;
  assign w_refill_done = (r_state == REFILL) & mem_ack_i;

  assign p1_stall_o = rst_i & (w_miss | (r_state != IDLE));
  assign p1_data_o  = (w_hit & p1_MemRead_i & ~p1_MemWrite_i) ? w_rd_word : 32'h0;

  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

  always_comb begin
    w_state_next      = r_state;
    w_mem_enable_next = r_mem_enable;
    w_mem_write_next  = r_mem_write;
    w_mem_addr_next   = r_mem_addr;
    w_mem_data_next   = r_mem_data;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          w_mem_enable_next = 1'b1;
          if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_state_next     = WRITEBACK;
            w_mem_write_next = 1'b1;
            w_mem_addr_next  = {r_tag[w_idx], w_idx, 5'b0};
            w_mem_data_next  = w_line;
          end else begin
            w_state_next     = REFILL;
            w_mem_write_next = 1'b0;
            w_mem_addr_next  = {w_tag, w_idx, 5'b0};
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          w_state_next     = REFILL;
          w_mem_write_next = 1'b0;
          w_mem_addr_next  = {r_req_tag, r_req_idx, 5'b0};
        end
      end
      REFILL: begin
        if (mem_ack_i) begin
          w_state_next      = IDLE;
          w_mem_enable_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mem_enable <= w_mem_enable_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_data   <= w_mem_data_next;
      if (w_miss) begin
        r_req_tag <= w_tag;
        r_req_idx <= w_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_refill_done) begin
      r_valid[r_req_idx] <= 1'b1;
      r_dirty[r_req_idx] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk_i) begin
    if (w_refill_done) begin
      r_data[r_req_idx] <= mem_data_i;
      r_tag[r_req_idx]  <= r_req_tag;
    end else if (w_write_hit) begin
      r_data[w_idx][{w_word, 5'b0} +: 32] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a flat word-level memory image is the reference for load data and
// write-back contents; a tag/valid/dirty policy model predicts stall lengths and memory traffic.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           lat      = 1;
  int           rsp_cnt  = 0;
  bit           spur_ack = 0;
  txn_t         txq[$];
  txn_t         last_wb;
  logic [31:0]  bk    [bit [29:0]];
  logic [31:0]  truth [bit [29:0]];
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bk_word(input logic [29:0] wa);
    if (bk.exists(wa)) return bk[wa];
    return ({wa, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] truth_word(input logic [29:0] wa);
    if (truth.exists(wa)) return truth[wa];
    return bk_word(wa);
  endfunction

  function automatic logic [255:0] truth_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = truth_word({la[31:5], 3'(w)});
    return l;
  endfunction

  // Memory responder: acks the lat-th cycle that mem_enable_o is seen high, one transaction at a time.
  always @(negedge clk_i) begin
    mem_ack_i  = 1'b0;
    mem_data_i = {8{$urandom}};
    if (!rst_i) begin
      rsp_cnt = 0;
    end else if (spur_ack) begin
      mem_ack_i = 1'b1;
    end else if (mem_enable_o) begin
      rsp_cnt++;
      if (rsp_cnt >= lat) begin
        txn_t t;
        rsp_cnt   = 0;
        mem_ack_i = 1'b1;
        t.wr   = mem_write_o;
        t.addr = mem_addr_o;
        if (mem_write_o) begin
          t.data = mem_data_o;
          for (int w = 0; w < 8; w++) bk[{mem_addr_o[31:5], 3'(w)}] = mem_data_o[w*32 +: 32];
        end else begin
          for (int w = 0; w < 8; w++) mem_data_i[w*32 +: 32] = bk_word({mem_addr_o[31:5], 3'(w)});
          t.data = mem_data_i;
        end
        txq.push_back(t);
      end
    end else begin
      rsp_cnt = 0;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
    end
    truth.delete();
    txq.delete();
  endtask

  // One pipeline access, entered and left just after a rising edge.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata);
    logic [4:0]   idx;
    logic [21:0]  tag;
    logic [31:0]  vaddr, laddr, exp_rd;
    logic [255:0] vline;
    bit           hit, dirty_victim;
    int           exp_stall, exp_txn, stalls;
    txn_t         t;
    idx          = addr[9:5];
    tag          = addr[31:10];
    laddr        = {addr[31:5], 5'b0};
    hit          = m_valid[idx] && (m_tag[idx] == tag);
    dirty_victim = !hit && m_valid[idx] && m_dirty[idx];
    vaddr        = {m_tag[idx], idx, 5'b0};
    vline        = truth_line(vaddr);
    exp_stall    = hit ? 0 : (dirty_victim ? 2 * lat + 1 : lat + 1);
    exp_txn      = hit ? 0 : (dirty_victim ? 2 : 1);
    exp_rd       = truth_word(addr[31:2]);
    txq.delete();
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    stalls = 0;
    @(negedge clk_i);
    while (p1_stall_o && stalls < 1000) begin
      stalls++;
      @(negedge clk_i);
    end
    chk("stall_cycles", 256'(stalls), 256'(exp_stall));
    chk("enable_after", 256'(mem_enable_o), 256'(0));
    if (rd && !wr) chk("load_data", 256'(p1_data_o), 256'(exp_rd));
    if (!rd) chk("data_zero", 256'(p1_data_o), 256'(0));
    chk("txn_count", 256'(txq.size()), 256'(exp_txn));
    if (dirty_victim && txq.size() > 0) begin
      t = txq.pop_front();
      last_wb = t;
      chk("wb_write", 256'(t.wr), 256'(1));
      chk("wb_addr", 256'(t.addr), 256'(vaddr));
      chk("wb_data", t.data, vline);
    end
    if (!hit && txq.size() > 0) begin
      t = txq.pop_front();
      chk("fetch_write", 256'(t.wr), 256'(0));
      chk("fetch_addr", 256'(t.addr), 256'(laddr));
    end
    $display("access wr=%0b rd=%0b addr=%h lat=%0d stalls=%0d", wr, rd, addr, lat, stalls);
    if (!hit) begin
      m_valid[idx] = 1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 0;
    end
    if (wr) begin
      m_dirty[idx] = 1;
      truth[addr[31:2]] = wdata;
    end
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_stall", 256'(p1_stall_o), 256'(0));
    chk("rst_data", 256'(p1_data_o), 256'(0));
    chk("rst_enable", 256'(mem_enable_o), 256'(0));
    chk("rst_write", 256'(mem_write_o), 256'(0));
    chk("rst_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_mdata", mem_data_o, 256'(0));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    bk[30'h10] = 32'h1234_5678;
    lat = 10;
    access(0, 1, 32'h0000_0040, 32'h0);
    access(0, 1, 32'h0000_0040, 32'h0);
    access(1, 0, 32'h0000_0044, 32'hDEAD_BEEF);
    access(0, 1, 32'h0000_0044, 32'h0);
    lat = 4;
    access(0, 1, 32'h0000_0440, 32'h0);
    chk("evict_addr", 256'(last_wb.addr), 256'(32'h40));
    chk("evict_word1", 256'(last_wb.data[63:32]), 256'(32'hDEAD_BEEF));
    lat = 3;
    access(1, 0, 32'h0000_0080, 32'hCAFE_F00D);
    access(0, 1, 32'h0000_0080, 32'h0);
    access(0, 1, 32'h0000_0480, 32'h0);
    chk("merged_wb", 256'(last_wb.data[31:0]), 256'(32'hCAFE_F00D));

    // A stray ack while idle must not disturb the cache.
    spur_ack = 1'b1;
    @(posedge clk_i);
    #1;
    spur_ack = 1'b0;
    access(0, 1, 32'h0000_0480, 32'h0);

    // Reset while the refill is outstanding.
    lat = 20;
    p1_MemRead_i = 1'b1;
    p1_addr_i    = 32'h0000_0100;
    repeat (6) @(negedge clk_i);
    chk("pre_rst_enable", 256'(mem_enable_o), 256'(1));
    rst_i = 1'b0;
    #1;
    chk("midrst_enable", 256'(mem_enable_o), 256'(0));
    chk("midrst_stall", 256'(p1_stall_o), 256'(0));
    chk("midrst_data", 256'(p1_data_o), 256'(0));
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    lat = 3;
    access(0, 1, 32'h0000_0100, 32'h0);
    access(0, 1, 32'h0000_0040, 32'h0);

    for (int i = 0; i < 300; i++) begin
      int unsigned op;
      logic [31:0] a;
      lat = $urandom_range(1, 6);
      op  = $urandom_range(0, 3);
      a   = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5)
          | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access(op == 1 || op == 2, op != 1, a, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the pipeline MEM stage (EX/MEM address, store data, MemRead/MemWrite) and an off-chip data memory with a 256-bit line interface.
- Returns read data to MEM/WB.
- Raises a stall that freezes the PC and all pipeline registers while a miss is serviced.

Parameters:
- INDEX_W, 5, line index width; the cache holds 2^INDEX_W lines.
- LINE_W, 256, line width in bits (8 words); fixed byte-offset field addr[4:0], word select addr[4:2].
- TAG_W, 32-5-INDEX_W (22), tag width; tag = addr[31:5+INDEX_W].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- p1_MemRead_i  in  1  MEM-stage load request.
- p1_MemWrite_i  in  1  MEM-stage store request; wins if both request inputs are high.
- p1_addr_i  in  32  byte address; bits [1:0] ignored.
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data, valid when p1_MemRead_i=1 and p1_stall_o=0.
- p1_stall_o  out  1  pipeline stall.
- mem_enable_o  out  1  off-chip request, held until ack.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address, bits [4:0] = 0.
- mem_data_o  out  256  write-back line.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Storage: per line valid, dirty, tag, 256-bit data. Only valid/dirty are reset; tag/data are not.
- Reset (rst_i=0, async):
  - state=IDLE, all valid=0, dirty=0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p1_stall_o=0, p1_data_o=0.
- Request: req = p1_MemRead_i | p1_MemWrite_i.
- Hit: hit = valid[idx] & (tag[idx] == addr tag), evaluated combinationally in IDLE only.
- p1_stall_o (combinational) = (state==IDLE & req & ~hit) | (state!=IDLE).
- Read hit: p1_data_o = line word addr[4:2] in the same cycle; zero latency, no stall.
- Write hit: at the clock edge, the selected word is replaced with p1_data_i and dirty[idx]=1; no stall.
- p1_data_o = 0 when no read hit is being returned.
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE, req & ~hit, victim valid & dirty -> WRITEBACK. mem_addr_o={victim tag, idx, 5'b0}, mem_data_o=victim line, mem_write_o=1, mem_enable_o=1 (all registered, visible the next cycle).
  - IDLE, req & ~hit, victim clean or invalid -> REFILL. mem_addr_o={req tag, idx, 5'b0}, mem_write_o=0, mem_enable_o=1.
  - WRITEBACK: outputs held stable. On mem_ack_i -> REFILL with mem_addr_o re-targeted to the requested line and mem_write_o=0; mem_enable_o stays 1.
  - REFILL: outputs held. On mem_ack_i:
    - line = mem_data_i, tag = request tag, valid=1, dirty=0;
    - mem_enable_o=0;
    - -> IDLE.
  - Next IDLE cycle: the request re-evaluates as a hit. The stall drops and a load returns data, or a store merges and sets dirty.
- Miss penalty: clean miss = memory latency + 1 cycle; dirty miss = 2 x latency + 1 cycle.
- Request inputs are not sampled outside IDLE; the pipeline holds them stable under stall. A transaction, once started, always completes even if req falls.
- mem_ack_i in IDLE is ignored.
- Exactly one outstanding memory transaction at a time.
- Reset mid-transaction: return to IDLE immediately and drop mem_enable_o. All lines become invalid and the in-flight write-back is lost (accepted).
- Index/tag wrap: addresses differing only in tag bits conflict on the same line; no associativity.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning word[0]=0x1234_5678 after an ack at 10 cycles -> stall high 11 cycles; one mem fetch, mem_addr_o=0x40, mem_write_o=0; then p1_data_o=0x1234_5678 with stall low.
- Repeat the load of 0x40 -> zero stall cycles, mem_enable_o stays 0, same data returned.
- Store 0xDEAD_BEEF to 0x44 (hit) -> no stall, dirty set. Then load 0x44 -> 0xDEAD_BEEF.
- Load 0x0000_0440 (same index, different tag, dirty victim):
  - first a write-back, mem_write_o=1, mem_addr_o=0x40, mem_data_o word[1]=0xDEAD_BEEF;
  - after its ack, a fetch with mem_addr_o=0x440;
  - stall lasts 2 x latency + 1 cycles.
- Store miss to clean line 0x80 -> fetch only, no write-back; after refill, the word merges and dirty=1. A later eviction writes back the merged value.
- Assert rst_i=0 mid-REFILL -> mem_enable_o=0 and stall=0 immediately. A following load to the same address misses again (valid cleared).
